// File: rtl/instr_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_loader_pkg : shared sizes and state encoding for instr_loader  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package instr_loader_pkg;

    localparam int INSTR_WRITE_WIDTH     = 32;
    localparam int LOG_WRITE_WINDOW_SIZE = 2;

    localparam int WIN_BYTES = INSTR_WRITE_WIDTH / 8;
    localparam int LOG_WIN   = LOG_WRITE_WINDOW_SIZE;
    localparam int CNT_WIDTH = 11;
    localparam int MAX_BYTES = 1024;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_loader_if : byte-stream input and memory write-port bundle     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface instr_loader_if #(
    parameter int WIN_BYTES = instr_loader_pkg::WIN_BYTES,
    parameter int LOG_WIN   = instr_loader_pkg::LOG_WIN
);
    logic                   i_byte_vld;
    logic [7:0]             i_byte;
    logic                   i_byte_last;
    logic                   o_byte_rdy;
    logic                   i_wr_rdy;
    logic                   o_we;
    logic [WIN_BYTES*8-1:0] o_wr_data;
    logic [LOG_WIN-1:0]     o_write_pointer_shift_minusone;

    // Loader side
    modport master (
        input  i_byte_vld, i_byte, i_byte_last, i_wr_rdy,
        output o_byte_rdy, o_we, o_wr_data, o_write_pointer_shift_minusone
    );

    // Byte source / memory side
    modport slave (
        output i_byte_vld, i_byte, i_byte_last, i_wr_rdy,
        input  o_byte_rdy, o_we, o_wr_data, o_write_pointer_shift_minusone
    );
endinterface
`default_nettype wire

// File: rtl/instr_loader_cksum.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | loader_cksum : mod-256 running sum of payload bytes with compare     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module loader_cksum
    import instr_loader_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_clr,
    input  wire logic       i_add,
    input  wire logic [7:0] i_byte,
    output logic            o_match
);
    logic [7:0] r_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
        end else if (i_clr) begin
            r_sum <= '0;
        end else if (i_add) begin
            r_sum <= r_sum + i_byte;
        end
    end

    assign o_match = (r_sum == i_byte);
endmodule
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_loader : packs a program byte stream into instruction-memory   |
// | write windows. Optional checksum trailer: LOADER_CKSUM_EN.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int WIN_BYTES = instr_loader_pkg::WIN_BYTES,
    parameter int LOG_WIN   = instr_loader_pkg::LOG_WIN,
    parameter int CNT_WIDTH = instr_loader_pkg::CNT_WIDTH,
    parameter int MAX_BYTES = instr_loader_pkg::MAX_BYTES
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_start,
    instr_loader_if.master         bus,
    output logic                   o_load_done,
    output logic                   o_load_err,
    output logic [CNT_WIDTH-1:0]   o_byte_count
);
    localparam logic [LOG_WIN:0]   c_win     = (LOG_WIN+1)'(WIN_BYTES);
    localparam logic [LOG_WIN:0]   c_one     = (LOG_WIN+1)'(1);
    localparam logic [CNT_WIDTH-1:0] c_max   = CNT_WIDTH'(MAX_BYTES);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

    loader_state_t          r_state;
    loader_state_t          w_state_nxt;
    logic [LOG_WIN:0]       r_cnt;
    logic [WIN_BYTES*8-1:0] r_window;
    logic                   r_last;
    logic                   r_err;
    logic                   r_cks_bad;
    logic [CNT_WIDTH-1:0]   r_count;

    logic                   w_is_cks;
    logic                   w_cks_match;
    logic                   w_byte_rdy;
    logic                   w_take;
    logic                   w_take_pay;
    logic                   w_take_cks;
    logic                   w_cks_bad;
    logic                   w_hs;
    logic                   w_arm;
    logic [LOG_WIN-1:0]     w_lane;

`ifdef LOADER_CKSUM_EN
    // The trailing byte is the checksum; it is compared, never stored or counted.
    assign w_is_cks = bus.i_byte_last;

    loader_cksum u_cksum (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_arm),
        .i_add   (w_take_pay),
        .i_byte  (bus.i_byte),
        .o_match (w_cks_match)
    );
`else
    assign w_is_cks    = 1'b0;
    assign w_cks_match = 1'b1;
`endif

    assign w_arm      = i_start && (r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_ERR);
    assign w_byte_rdy = (r_state == ST_FILL) && ((r_count != c_max) || w_is_cks);
    assign w_take     = w_byte_rdy && bus.i_byte_vld;
    assign w_take_pay = w_take && !w_is_cks;
    assign w_take_cks = w_take && w_is_cks;
    assign w_cks_bad  = w_take_cks && !w_cks_match;
    assign w_hs       = (r_state == ST_WRITE) && bus.i_wr_rdy;
    assign w_lane     = r_cnt[LOG_WIN-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) w_state_nxt = ST_FILL;
            end
            ST_FILL: begin
                // A byte offered but refused in FILL can only mean capacity is exhausted.
                if (bus.i_byte_vld && !w_byte_rdy) begin
                    w_state_nxt = ST_ERR;
                end else if (w_take_cks) begin
                    w_state_nxt = (r_cnt == '0) ? ST_DONE : ST_WRITE;
                end else if (w_take_pay && (((r_cnt + c_one) == c_win) || bus.i_byte_last)) begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (w_hs) w_state_nxt = r_last ? ST_DONE : ST_FILL;
            end
            ST_DONE, ST_ERR: begin
                if (i_start) w_state_nxt = ST_FILL;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_window  <= '0;
            r_last    <= 1'b0;
            r_err     <= 1'b0;
            r_cks_bad <= 1'b0;
            r_count   <= '0;
        end else if (w_arm) begin
            r_cnt     <= '0;
            r_window  <= '0;
            r_last    <= 1'b0;
            r_err     <= 1'b0;
            r_cks_bad <= 1'b0;
            r_count   <= '0;
        end else begin
            if (w_take_pay) begin
                r_window[32'(w_lane)*8 +: 8] <= bus.i_byte;
                r_cnt   <= r_cnt + c_one;
                r_count <= r_count + c_cnt_one;
                r_last  <= bus.i_byte_last;
            end
            if (w_take_cks) begin
                r_last    <= 1'b1;
                r_cks_bad <= w_cks_bad;
            end
            if (w_hs) begin
                r_cnt    <= '0;
                r_window <= '0;
            end
            // A bad checksum is reported only once the final window has been written.
            if ((w_state_nxt == ST_ERR) ||
                ((w_state_nxt == ST_DONE) && (r_cks_bad || w_cks_bad))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.o_byte_rdy = w_byte_rdy;
    assign bus.o_we       = (r_state == ST_WRITE);
    assign bus.o_wr_data  = (r_state == ST_WRITE) ? r_window : '0;
    assign bus.o_write_pointer_shift_minusone =
        (r_state == ST_WRITE) ? LOG_WIN'(r_cnt - c_one) : '0;

    assign o_load_done  = (r_state == ST_DONE);
    assign o_load_err   = r_err;
    assign o_byte_count = r_count;
endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instr_loader : scoreboard bench for instr_loader (MAX_BYTES=14)   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_instr_loader;
    localparam int TB_MAX = 14;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [31:0] data;
        logic [1:0]  shm1;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        load_done;
    logic        load_err;
    logic [10:0] byte_count;

    bit  hold_rdy = 1'b0;
    bit  rnd_rdy  = 1'b0;
    int  n_vec = 0;
    int  n_err = 0;
    wr_t exp_q[$];
    bit          exp_done;
    bit          exp_err;
    int          exp_cnt;

    instr_loader_if #(.WIN_BYTES(4), .LOG_WIN(2)) bus ();

    instr_loader #(
        .WIN_BYTES(4), .LOG_WIN(2), .CNT_WIDTH(11), .MAX_BYTES(TB_MAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (start),
        .bus          (bus),
        .o_load_done  (load_done),
        .o_load_err   (load_err),
        .o_byte_count (byte_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: bytes are accepted up to capacity, grouped four at a time,
    // lowest-address byte in the low lane; an overflowed tail window is dropped.
    task automatic model_push(input bq_t s, input bit has_last);
        bq_t         pay;
        bit          ovf;
        int          acc;
        logic [7:0]  cks;
        logic [7:0]  sum;
        wr_t         w;
        pay = s;
        cks = 8'h00;
        sum = 8'h00;
`ifdef LOADER_CKSUM_EN
        if (has_last) cks = pay.pop_back();
`endif
        ovf = (pay.size() > TB_MAX);
        acc = ovf ? TB_MAX : pay.size();
        for (int k = 0; k < acc; k += 4) begin
            int len;
            len = (acc - k < 4) ? acc - k : 4;
            if (ovf && len < 4) break;
            w.data = 32'h0;
            for (int j = 0; j < len; j++) w.data = w.data | (32'(pay[k+j]) << (8*j));
            w.shm1 = 2'(len - 1);
            exp_q.push_back(w);
        end
        foreach (pay[k]) sum = sum + pay[k];
        exp_done = !ovf;
        exp_err  = ovf;
        exp_cnt  = acc;
`ifdef LOADER_CKSUM_EN
        if (!ovf && has_last) exp_err = (sum != cks);
`else
        if (has_last && sum == 8'h00) exp_err = ovf;
`endif
    endtask

    function automatic bq_t with_ck(input bq_t p, input bit bad);
        bq_t        r;
        logic [7:0] s;
        r = p;
        s = 8'h00;
`ifdef LOADER_CKSUM_EN
        foreach (p[k]) s = s + p[k];
        r.push_back(bad ? (s ^ 8'h01) : s);
`else
        if (bad) s = 8'h01;
`endif
        return r;
    endfunction

    task automatic arm();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("arm_done_clear", 32'(load_done), 32'h0);
        chk("arm_err_clear", 32'(load_err), 32'h0);
        chk("arm_count_clear", 32'(byte_count), 32'h0);
    endtask

    task automatic offer(input logic [7:0] b, input bit l, input bit rnd_start, output bit abort);
        int to;
        abort = 1'b0;
        bus.i_byte      = b;
        bus.i_byte_vld  = 1'b1;
        bus.i_byte_last = l;
        start = rnd_start && ($urandom_range(0, 4) == 0);
        to = 0;
        forever begin
            @(negedge clk);
            if (bus.o_byte_rdy) begin
                @(posedge clk); #1;
                break;
            end else if (load_err) begin
                abort = 1'b1;
                break;
            end else if (++to > 100) begin
                n_vec++; n_err++;
                $display("FAIL byte_accept_timeout: got no ready expected ready within 100 cycles");
                abort = 1'b1;
                break;
            end
        end
        start = 1'b0;
        bus.i_byte_vld  = 1'b0;
        bus.i_byte_last = 1'b0;
    endtask

    task automatic run_stream(input bq_t s, input bit has_last);
        bit abort;
        int to;
        model_push(s, has_last);
        arm();
        abort = 1'b0;
        for (int i = 0; i < s.size() && !abort; i++)
            offer(s[i], has_last && (i == s.size() - 1), i < TB_MAX - 1, abort);
        to = 0;
        @(negedge clk);
        while (!(load_done || load_err) && to < 300) begin
            @(negedge clk);
            to++;
        end
        chk("final_done", 32'(load_done), 32'(exp_done));
        chk("final_err", 32'(load_err), 32'(exp_err));
        chk("final_count", 32'(byte_count), 32'(exp_cnt));
        chk("writes_outstanding", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
    endtask

    // Memory-side ready
    initial begin
        bus.i_wr_rdy = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.i_wr_rdy = hold_rdy ? 1'b0 : (rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1);
        end
    end

    // Monitor: checks every completed write against the scoreboard and
    // checks that a stalled write holds its payload.
    initial begin : mon
        bit          prev_stall;
        logic [31:0] prev_d;
        logic [1:0]  prev_s;
        wr_t         e;
        prev_stall = 1'b0;
        prev_d = 32'h0;
        prev_s = 2'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else if (bus.o_we) begin
                chk("rdy_low_in_write", 32'(bus.o_byte_rdy), 32'h0);
                if (prev_stall) begin
                    chk("stall_data_stable", bus.o_wr_data, prev_d);
                    chk("stall_shift_stable", 32'(bus.o_write_pointer_shift_minusone), 32'(prev_s));
                end
                if (bus.i_wr_rdy) begin
                    if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_write: got data 0x%0h expected no write", bus.o_wr_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_data", bus.o_wr_data, e.data);
                        chk("wr_shift_minusone", 32'(bus.o_write_pointer_shift_minusone), 32'(e.shm1));
                    end
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev_d = bus.o_wr_data;
                    prev_s = bus.o_write_pointer_shift_minusone;
                end
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin : stim
        bq_t q;
        bit  abort;
        bus.i_byte_vld  = 1'b0;
        bus.i_byte      = 8'h00;
        bus.i_byte_last = 1'b0;

        @(negedge clk);
        chk("rst_we", 32'(bus.o_we), 32'h0);
        chk("rst_rdy", 32'(bus.o_byte_rdy), 32'h0);
        chk("rst_done", 32'(load_done), 32'h0);
        chk("rst_err", 32'(load_err), 32'h0);
        chk("rst_count", 32'(byte_count), 32'h0);
        chk("rst_data", bus.o_wr_data, 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        // Two full windows
        q = {};
        for (int i = 1; i <= 8; i++) q.push_back(8'(i));
        run_stream(with_ck(q, 1'b0), 1'b1);

        // Partial final window
        q = {};
        for (int i = 0; i < 5; i++) q.push_back(8'(8'hA0 + i));
        run_stream(with_ck(q, 1'b0), 1'b1);

        // Ten-cycle memory stall
        q = '{8'h11, 8'h22, 8'h33, 8'h44};
        hold_rdy = 1'b1;
        fork
            run_stream(with_ck(q, 1'b0), 1'b1);
            begin
                int to;
                to = 0;
                while (!bus.o_we && to < 100) begin
                    @(negedge clk);
                    to++;
                end
                repeat (10) @(posedge clk);
                #1 hold_rdy = 1'b0;
            end
        join

        // Overflow: one byte beyond capacity, no last marker
        q = {};
        for (int i = 0; i <= TB_MAX; i++) q.push_back(8'($urandom));
        run_stream(q, 1'b0);

        // Capacity exactly reached with last marker
        q = {};
        for (int i = 0; i < TB_MAX; i++) q.push_back(8'($urandom));
        run_stream(with_ck(q, 1'b0), 1'b1);

        // Reset mid-window drops the partial window
        arm();
        offer(8'h5A, 1'b0, 1'b0, abort);
        offer(8'hA5, 1'b0, 1'b0, abort);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_we", 32'(bus.o_we), 32'h0);
        chk("midrst_rdy", 32'(bus.o_byte_rdy), 32'h0);
        chk("midrst_count", 32'(byte_count), 32'h0);
        chk("midrst_done", 32'(load_done), 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_stream(with_ck(q, 1'b0), 1'b1);

`ifdef LOADER_CKSUM_EN
        q = '{8'h10, 8'h20, 8'h30};
        run_stream(q, 1'b1);
        q = '{8'h10, 8'h20, 8'h31};
        run_stream(q, 1'b1);
        q = '{8'h00};
        run_stream(q, 1'b1);
`endif

        // Randomized streams with random memory back-pressure
        rnd_rdy = 1'b1;
        for (int t = 0; t < 40; t++) begin
            int n;
            q = {};
            if ($urandom_range(0, 7) == 0) begin
                n = TB_MAX + 1 + $urandom_range(0, 2);
                for (int i = 0; i < n; i++) q.push_back(8'($urandom));
                run_stream(q, 1'b0);
            end else begin
`ifdef LOADER_CKSUM_EN
                n = $urandom_range(0, TB_MAX + 1);
`else
                n = $urandom_range(1, TB_MAX + 1);
`endif
                for (int i = 0; i < n; i++) q.push_back(8'($urandom));
                run_stream(with_ck(q, $urandom_range(0, 3) == 0), 1'b1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Byte-stream loader that fills the instruction memory controller's write port, which the CPU top currently ties off (write enable 0).
- Packs incoming program bytes into write windows of up to WIN_BYTES bytes.
- Drives write enable, window data and shift-minus-one byte count with a valid/ready handshake.
- Reports completion, error and total byte count so the CPU can be released once the program is loaded.

Parameters:
- WIN_BYTES, 4, bytes per write window; equals instr_write_width/8.
- LOG_WIN, 2, log2(WIN_BYTES); equals log_write_window_size.
- CNT_WIDTH, 11, width of the total byte counter.
- MAX_BYTES, 1024, instruction memory capacity in bytes; must satisfy MAX_BYTES < 2^CNT_WIDTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- i_start  in  1  arm or re-arm the loader; sampled only in IDLE, DONE and ERR.
- i_byte_vld  in  1  input byte valid.
- i_byte  in  8  program byte.
- i_byte_last  in  1  marks the final byte of the stream; qualified by i_byte_vld.
- o_byte_rdy  out  1  loader accepts a byte this cycle.
- i_wr_rdy  in  1  instruction memory can accept a write.
- o_we  out  1  write request valid.
- o_wr_data  out  WIN_BYTES*8  packed window.
- o_write_pointer_shift_minusone  out  LOG_WIN  valid bytes in the window minus 1.
- o_load_done  out  1  level signal: load finished.
- o_load_err  out  1  level signal, sticky: load failed.
- o_byte_count  out  CNT_WIDTH  payload bytes accepted since the last i_start.

Behaviour:
- Reset (async, rst=1):
  - State IDLE.
  - All outputs 0.
  - Window buffer and lane counter cleared.
  - A partially filled window is discarded and no o_we is issued.
- States: IDLE, FILL, WRITE, DONE, ERR.
- IDLE: o_byte_rdy=0. On i_start=1 go to FILL; clear o_byte_count, window and lane counter.
- FILL:
  - o_byte_rdy=1.
  - A byte is accepted when i_byte_vld and o_byte_rdy are both 1 at the clock edge.
  - The byte goes to lane cnt (bits 8*cnt+7 : 8*cnt). Packing is little-endian: the earliest byte sits in the lowest lane.
  - Each accepted byte increments cnt and o_byte_count.
  - If cnt reaches WIN_BYTES, or the byte has i_byte_last=1, go to WRITE on the next cycle.
  - Overflow: a byte offered while o_byte_count==MAX_BYTES is not accepted. The loader goes to ERR and does not write the partial window.
- WRITE:
  - o_byte_rdy=0.
  - o_we=1, o_wr_data = window with unused upper lanes zero, o_write_pointer_shift_minusone = cnt-1.
  - These outputs are held stable until i_wr_rdy=1 at a clock edge, which completes the handshake.
  - After the handshake: if the window held the last byte, go to DONE; otherwise go to FILL with cnt=0 and the window zeroed.
- DONE: o_load_done=1. i_start re-arms the loader (go to FILL, clear count, o_load_done=0).
- ERR: o_load_err=1, o_byte_rdy=0. Exit only via i_start, which clears err and count.
- i_start in FILL or WRITE is ignored.
- Latency: byte accepted at edge N (completing a window) → o_we=1 during cycle N+1.
- Steady-state throughput: WIN_BYTES bytes per WIN_BYTES+1 cycles when i_wr_rdy=1.
- i_byte_vld with i_byte_last=1 arriving exactly when o_byte_count==MAX_BYTES-1 is legal: accepted, flushed, DONE.

Optional Feature:
- Macro: LOADER_CKSUM_EN.
- Defined:
  - The stream's last byte is an 8-bit checksum: the mod-256 sum of all payload bytes.
  - The checksum byte is not written and not counted.
  - If the checksum arrives with cnt==0, go directly to DONE with no write.
  - On mismatch: DONE with o_load_done=1 and o_load_err=1.
  - Running sum cleared on i_start.
- Not defined: the last byte is ordinary payload, and o_load_err signals overflow only.

Decomposition:
- Shared defines/package: WIN_BYTES, LOG_WIN (aliasing instr_write_width and log_write_window_size), MAX_BYTES, state encodings.
- One sub-module: loader_cksum (running sum, clear, compare), instantiated only under LOADER_CKSUM_EN.

Test Plan:
- Stream 8 bytes 0x01..0x08 (last on 0x08), i_wr_rdy=1 → two writes, 0x04030201 then 0x08070605, shift_minusone=3 for both; then done=1, count=8.
- Stream 5 bytes 0xA0..0xA4 → second write 0x000000A4 with shift_minusone=0; done=1, count=5.
- Hold i_wr_rdy=0 for 10 cycles during WRITE → o_we, data and shift_minusone stable and o_byte_rdy=0 throughout; write completes on the first cycle i_wr_rdy=1.
- MAX_BYTES=8, stream 9 bytes with no last → 2 writes, 9th byte not accepted, err=1, done=0; i_start clears err and count.
- Assert rst mid-window after 2 bytes → no o_we; outputs 0; next i_start load of 4 bytes produces a single write.
- With LOADER_CKSUM_EN: payload 0x10, 0x20, checksum 0x30 → one write 0x00002010, shift_minusone=1, done=1, err=0, count=2. Checksum 0x31 → done=1, err=1.
